my_uart_tx: RTL and testbench
=============================

# my_uart_tx

- Byte-wide RS232 transmitter: the transmit-side counterpart of the UART receive path.
- Accepts bytes over a valid/ready handshake into a one-deep holding register and serialises them LSB-first as 8-N-1 frames. Optional parity and a second stop bit are set by parameter.
- Sits between the system logic and the `rs232_tx` pin, on the same 50 MHz clock as the receiver. Its bit timing comes from a dedicated baud-tick sub-module using the same `bps_start`/`clk_bps` handshake as the receive path.

## Interface

Parameters:
- `CLK_FREQ`, default 50_000_000: input clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
  - Bit period `DIV = CLK_FREQ/BAUD`, using integer truncation.
  - `DIV` must be at least 4; elaboration fails otherwise.
- `PARITY_EN`, default 0: 1 inserts a parity bit after bit 7.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk`, input, 1: system clock. All logic is clocked on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `tx_data`, input, 8: byte to send. Sampled when `tx_valid && tx_ready`.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: holding register is empty.
- `rs232_tx`, output, 1: serial line. Registered; idles high.
- `tx_busy`, output, 1: high while the FSM is not in IDLE.
- `tx_done`, output, 1: one-cycle pulse at the end of each frame's last stop bit.

## Operation

Reset values: `rs232_tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. On reset the FSM is in IDLE, the holding register is empty and the baud counter is 0.

Handshake:
- `tx_ready` is a registered signal equal to "holding register empty".
- A byte is accepted only on an edge where `tx_valid && tx_ready` is true.
- The byte is latched and `tx_ready` falls on that same edge.
- Bytes may be accepted while a frame is in flight.

FSM states:
- IDLE
  - If the holding register is full: load the shift register from it, clear the holding register (`tx_ready` rises), drive `rs232_tx` to 0, assert `bps_start`, go to START.
- START: after one bit period, go to DATA and drive bit 0.
- DATA: drive bits 0..7, one per bit period, LSB first.
  - After bit 7, go to PARITY if `PARITY_EN`, otherwise go to STOP.
- PARITY
  - Value is XOR of the 8 data bits.
  - The value is inverted when `PARITY_ODD`.
- STOP: drive 1 for `STOP_BITS` bit periods. At the end:
  - Pulse `tx_done`.
  - If the holding register is full, reload it and go straight to START, driving 0 on the same edge. There is no idle gap between frames.
  - Otherwise go to IDLE and deassert `bps_start`.

Boundary rules:
- `tx_valid` while `tx_ready`=0: ignored. `tx_data` is not sampled.
- `tx_data` changing after acceptance: no effect on the frame.
- Reload and a new acceptance cannot occur on the same edge: `tx_ready` is 0 on that edge.
- Reset asserted mid-frame:
  - Frame is aborted and `rs232_tx` goes high immediately.
  - Any byte in the holding register is discarded.
  - No `tx_done` is generated.

## Timing

- Acceptance at edge E0 with the FSM in IDLE: `rs232_tx` falls at E1.
- Every bit, including start, parity and stop bits, lasts exactly `DIV` clocks.
- Frame length is `(10 + PARITY_EN + STOP_BITS - 1) * DIV` clocks.
- `tx_done` is high during the cycle after the last stop-bit tick.
- Back-to-back frames: the next start bit begins on the edge where `tx_done` is asserted.
- `tx_busy` rises at E1 and falls on the edge that enters IDLE.

## Structure

Shared package `uart_pkg`:
- FSM state encoding: IDLE, START, DATA, PARITY, STOP.
- Frame constants: data width 8.
- Function `bps_div(clk_freq, baud)`.

Sub-module `uart_bps_gen`, ports `clk`, `rst_n`, `bps_start` (in), `clk_bps` (out):
- Counter runs 0..DIV-1 while `bps_start` is high.
- `clk_bps` is a one-cycle pulse when the counter equals DIV-1; the counter then wraps to 0.
- Counter is held at 0 while `bps_start` is low.
- Reusable for the receive side with a half-period offset variant.

`my_uart_tx` contains the FSM, the 8-bit shift register, the bit counter (4 bits), the stop-bit counter, and the holding register.

## Test plan

Benches use `CLK_FREQ`=1_000_000, `BAUD`=100_000 (`DIV`=10) unless stated.

1. Single byte 0x55, no parity: accept at cycle 0 → line falls at cycle 1, then bits 1,0,1,0,1,0,1,0 (LSB first) at 10 clocks each, stop bit high. `tx_done` pulses at cycle 101. `tx_busy` covers cycles 1–100.
2. Back-to-back 0xA3 then 0x0F: second byte accepted during the first frame → second start bit begins on the `tx_done` edge with no high gap. Both bytes decode correctly. `tx_ready` rises when the first byte is loaded.
3. Back-pressure: hold `tx_valid` with changing data while `tx_ready`=0 → only bytes presented while `tx_ready`=1 appear on the line, in order, with none lost or duplicated.
4. `PARITY_EN`=1 with 0x07:
   - `PARITY_ODD`=0 → parity bit 1.
   - `PARITY_ODD`=1 → parity bit 0.
   - Frame is 110 clocks.
5. `STOP_BITS`=2 with 0xFF → line high for 20 clocks after bit 7 before `tx_done`. The next start bit is no earlier than that.
6. Reset mid-frame at bit 4 with a byte pending → `rs232_tx`=1 and `tx_ready`=1 immediately, no `tx_done`. After release, a new byte 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART states, frame constants and baud divisor helper
package uart_pkg;

    // Transmit FSM states, in frame order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_W = 8;

    // Clocks per bit, truncated.
    function automatic int bps_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bps_gen.sv
// rtl/uart_bps_gen.sv - bit-period tick generator driven by the bps_start handshake
module uart_bps_gen #(
    parameter int DIV = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bps_start,
    output logic clk_bps
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1 while a frame is running; parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!bps_start || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign clk_bps = bps_start && (cnt == LAST);

endmodule

// File: rtl/my_uart_tx.sv
// rtl/my_uart_tx.sv - byte-wide RS232 transmitter with one-deep holding register
module my_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rs232_tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int   DIV    = bps_div(CLK_FREQ, BAUD);
    localparam logic PAR_EN = (PARITY_EN != 0);
    localparam logic ODD    = (PARITY_ODD != 0);
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    if (DIV < 4) begin : g_bad_div
        $error("my_uart_tx: CLK_FREQ/BAUD must be at least 4");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("my_uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t         state, state_d;
    logic [DATA_W-1:0] hold, hold_d;
    logic              hold_empty, hold_empty_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic [3:0]        bit_cnt, bit_cnt_d;
    logic              stop_cnt, stop_cnt_d;
    logic              par, par_d;
    logic              line, line_d;
    logic              bps_start, bps_start_d;
    logic              done, done_d;
    logic              clk_bps;
    logic              load;
    logic              stop_last;

    uart_bps_gen #(.DIV(DIV)) u_bps (
        .clk       (clk),
        .rst_n     (rst_n),
        .bps_start (bps_start),
        .clk_bps   (clk_bps)
    );

    assign stop_last = (STOP_BITS == 2) ? stop_cnt : 1'b1;

    // Next-state logic: frame sequencing, reload from the holding register, byte acceptance.
    always_comb begin
        state_d      = state;
        hold_d       = hold;
        hold_empty_d = hold_empty;
        shift_d      = shift;
        bit_cnt_d    = bit_cnt;
        stop_cnt_d   = stop_cnt;
        par_d        = par;
        line_d       = line;
        bps_start_d  = bps_start;
        done_d       = 1'b0;
        load         = 1'b0;

        case (state)
            IDLE: begin
                if (!hold_empty) begin
                    load        = 1'b1;
                    line_d      = 1'b0;
                    bps_start_d = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (clk_bps) begin
                    line_d    = shift[0];
                    bit_cnt_d = 4'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_bps) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PAR_EN) begin
                            line_d  = par;
                            state_d = PARITY;
                        end else begin
                            line_d     = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = STOP;
                        end
                    end else begin
                        shift_d   = {1'b0, shift[DATA_W-1:1]};
                        line_d    = shift[1];
                        bit_cnt_d = bit_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (clk_bps) begin
                    line_d     = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (clk_bps) begin
                    if (stop_last) begin
                        done_d = 1'b1;
                        if (!hold_empty) begin
                            // Back-to-back: the next start bit begins on this edge.
                            load    = 1'b1;
                            line_d  = 1'b0;
                            state_d = START;
                        end else begin
                            line_d      = 1'b1;
                            bps_start_d = 1'b0;
                            state_d     = IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                line_d      = 1'b1;
                bps_start_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // A reload only happens with the register full, so it never collides with acceptance.
        if (load) begin
            shift_d      = hold;
            par_d        = (^hold) ^ ODD;
            hold_empty_d = 1'b1;
        end else if (tx_valid && hold_empty) begin
            hold_d       = tx_data;
            hold_empty_d = 1'b0;
        end
    end

    // State and datapath registers; reset aborts any frame and drops a pending byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            hold_empty <= 1'b1;
            shift      <= '0;
            bit_cnt    <= 4'd0;
            stop_cnt   <= 1'b0;
            par        <= 1'b0;
            line       <= 1'b1;
            bps_start  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            hold       <= hold_d;
            hold_empty <= hold_empty_d;
            shift      <= shift_d;
            bit_cnt    <= bit_cnt_d;
            stop_cnt   <= stop_cnt_d;
            par        <= par_d;
            line       <= line_d;
            bps_start  <= bps_start_d;
            done       <= done_d;
        end
    end

    assign tx_ready = hold_empty;
    assign rs232_tx = line;
    assign tx_busy  = (state != IDLE);
    assign tx_done  = done;

endmodule

// File: tb/tb_my_uart_tx.sv
// tb/tb_my_uart_tx.sv - randomized bench for my_uart_tx against a frame-timing model
module tb_my_uart_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = 10;
    localparam int N        = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_valid = 1'b0;
    logic [7:0]   tx_data = 8'h00;
    logic [N-1:0] tx_ready, rs232_tx, tx_busy, tx_done;

    always #5 clk = ~clk;

    // 0: 8-N-1, 1: even parity, 2: odd parity, 3: two stop bits
    for (genvar g = 0; g < N; g++) begin : g_dut
        my_uart_tx #(
            .CLK_FREQ   (CLK_FREQ),
            .BAUD       (BAUD),
            .PARITY_EN  ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD ((g == 2) ? 1 : 0),
            .STOP_BITS  ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready[g]),
            .rs232_tx (rs232_tx[g]),
            .tx_busy  (tx_busy[g]),
            .tx_done  (tx_done[g])
        );
    end

    int cfg_pe[N] = '{0, 1, 1, 0};
    int cfg_po[N] = '{0, 0, 1, 0};
    int cfg_sb[N] = '{1, 1, 1, 2};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a frame starts at max(accept+1, previous frame end) and lasts bits*DIV clocks.
    bit         m_hold_full[N];
    logic [7:0] m_hold[N];
    int         m_acc[N];
    bit         m_active[N];
    logic [7:0] m_byte[N];
    int         m_start[N];
    bit         m_done[N];
    int         t = 0;

    function automatic int frame_bits(input int k);
        return 9 + cfg_pe[k] + cfg_sb[k];
    endfunction

    function automatic logic frame_bit(input int k, input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (n == 9 && cfg_pe[k] != 0) return (^b) ^ (cfg_po[k] != 0);
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_hold_full[k] = 1'b0;
            m_active[k]    = 1'b0;
            m_done[k]      = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            bit acc;
            acc = tx_valid && !m_hold_full[k];
            m_done[k] = 1'b0;
            if (m_active[k] && t == m_start[k] + frame_bits(k) * DIV) begin
                m_done[k]   = 1'b1;
                m_active[k] = 1'b0;
            end
            if (!m_active[k] && m_hold_full[k] && t >= m_acc[k] + 1) begin
                m_active[k]    = 1'b1;
                m_byte[k]      = m_hold[k];
                m_start[k]     = t;
                m_hold_full[k] = 1'b0;
            end
            if (acc) begin
                m_hold_full[k] = 1'b1;
                m_hold[k]      = tx_data;
                m_acc[k]       = t;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            logic exp_line;
            exp_line = m_active[k] ? frame_bit(k, m_byte[k], (t - m_start[k]) / DIV) : 1'b1;
            check($sformatf("line[%0d]@%0d", k, t), 32'(rs232_tx[k]), 32'(exp_line));
            check($sformatf("ready[%0d]@%0d", k, t), 32'(tx_ready[k]), 32'(!m_hold_full[k]));
            check($sformatf("busy[%0d]@%0d", k, t), 32'(tx_busy[k]), 32'(m_active[k]));
            check($sformatf("done[%0d]@%0d", k, t), 32'(tx_done[k]), 32'(m_done[k]));
        end
    endtask

    // One clock: model the edge with the inputs the DUT saw, then check at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all();
        if (rst_n) t++;
    endtask

    int first_fall;
    int first_done;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Single 0x55 accepted at edge 0.
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        first_fall = -1;
        first_done = -1;
        for (int i = 0; i < 150; i++) begin
            int te;
            te = t;
            cycle();
            tx_valid = 1'b0;
            if (first_fall < 0 && rs232_tx[0] == 1'b0) first_fall = te;
            if (first_done < 0 && tx_done[0] == 1'b1) first_done = te;
        end
        check("t1_fall_cycle", 32'(first_fall), 32'd1);
        check("t1_done_cycle", 32'(first_done), 32'd101);

        // Heavy back-pressure: valid mostly high, data changing every cycle.
        for (int i = 0; i < 3000; i++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            cycle();
        end

        // Sparse traffic: acceptances from idle and mid-frame.
        for (int i = 0; i < 2000; i++) begin
            tx_valid = ($urandom_range(0, 149) == 0);
            tx_data  = 8'($urandom);
            cycle();
        end
        tx_valid = 1'b0;
        repeat (200) cycle();

        // Reset during bit 4 with a second byte pending.
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            cycle();
        end
        tx_valid = 1'b0;
        while (t < m_start[0] + 5 * DIV + 4) cycle();
        check("rst_pending_before", 32'(tx_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_line[%0d]", k), 32'(rs232_tx[k]), 32'd1);
            check($sformatf("rst_ready[%0d]", k), 32'(tx_ready[k]), 32'd1);
            check($sformatf("rst_busy[%0d]", k), 32'(tx_busy[k]), 32'd0);
            check($sformatf("rst_done[%0d]", k), 32'(tx_done[k]), 32'd0);
        end
        repeat (3) cycle();
        rst_n = 1'b1;

        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        cycle();
        tx_valid = 1'b0;
        repeat (200) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
